seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

- Drives a 6-digit common-anode seven-segment display from the packed time word produced by the time counter: {hours[4:0], minutes[5:0], seconds[5:0]}.
- Latches a frame-coherent snapshot of the time word once per scan frame.
- Splits each field into tens/ones digits and time-multiplexes them onto shared segment lines.
- Inserts a blanking gap at the start of every digit slot to suppress ghosting.

## Interface
Parameters:
- SCAN_TIME, 50_000: cycles per digit slot (1 ms at 50 MHz). Legal range: ≥ 2.
- BLANK_TIME, 500: cycles at the start of each slot with all digits off. Legal range: 0 ≤ BLANK_TIME < SCAN_TIME.

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  reset; synchronous, active-high.
- din  input  17  packed time word: [16:12] hours, [11:6] minutes, [5:0] seconds.
- sel  output  6  digit enables, active-low; sel[0] is the rightmost digit.
- seg  output  8  segment lines, active-low; [7] = dp, [6:0] = g..a.

## Operation
- Slot counter cnt runs 0..SCAN_TIME-1 and wraps. Width is $clog2(SCAN_TIME).
- Digit index idx runs 0..5. It advances when cnt == SCAN_TIME-1; from 5 it wraps to 0.
- Digit mapping by idx:
  - 0 = seconds ones, 1 = seconds tens
  - 2 = minutes ones, 3 = minutes tens
  - 4 = hours ones, 5 = hours tens
- Snapshot register snap:
  - snap <= din on the cycle where cnt == SCAN_TIME-1 and idx == 5.
  - din is ignored at all other cycles, so a frame never tears.
- BCD split: tens = field / 10, ones = field % 10.
  - No saturation: out-of-range values are displayed arithmetically (minutes 63 → "63", hours 31 → "31").
- Segment codes (active-low, dp off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99
  - 5=92, 6=82, 7=F8, 8=80, 9=90
- Decimal point: lit (seg[7]=0) on idx 2 and idx 4, giving HH.MM.SS. Off on every other digit.
- Blanking: while cnt < BLANK_TIME, sel = 6'h3F and seg = 8'hFF.
- Otherwise: sel = ~(6'b1 << idx), and seg = the code for the selected digit.

## Timing
- Reset (rst high at a clk edge): cnt=0, idx=0, snap=0, sel=6'h3F, seg=8'hFF, all on the next edge.
- Reset mid-frame aborts the scan immediately. The next frame starts at idx 0 with snap = 0.
- sel and seg are registered: each reflects the cnt/idx/snap values of the previous cycle (1-cycle latency).
- First frame after reset displays 00.00.00. A din value first appears in the frame after the snapshot edge that captures it.
- Worst case din-change → display: 6·SCAN_TIME + 1 cycles.
- BLANK_TIME = 0: no blank cycles; the digit is driven for the entire slot.
- Slot boundary: the last visible cycle of digit k is followed directly by the blank cycles of digit k+1.
  - sel never has two bits low at once.
- Simultaneous events: when the snapshot is taken at cnt == SCAN_TIME-1, idx == 5, the registered output for that cycle still uses the old snap. The new snap takes effect from idx 0 of the next frame.

## Structure
- Shared package seg_pkg holds:
  - SEG_CODE[0:9] constants
  - SEG_BLANK = 8'hFF
  - NUM_DIGITS = 6
  - field bit positions (HOUR_MSB/LSB, MIN_MSB/LSB, SEC_MSB/LSB)
  - DP_MASK = 6'b010100
- One sub-module: bin2bcd_2d
  - Combinational 6-bit binary → {tens[3:0], ones[3:0]}.
  - Instantiated three times on snap fields; hours are zero-extended to 6 bits.
- Top level contains cnt, idx, snap, the digit mux and the output registers.

## Test plan
- Bench parameters: SCAN_TIME=8, BLANK_TIME=2.
- Reset release with din=0:
  - sel=3F, seg=FF at the first edge.
  - Slot 0: 2 blank cycles, then 6 cycles of sel=3E, seg=C0.
  - Slot 2 shows seg=40 (dp lit).
- din=17'h{12,34,56} (h=12, m=34, s=56) applied mid-frame:
  - Current frame remains 00.00.00.
  - Next frame shows digits 6,5,4,3,2,1 on idx 0..5.
  - Codes 82,92,19(4+dp),B0,24(2+dp),F9.
- din changed on every cycle during a frame: the displayed frame equals din exactly as sampled at the snapshot edge.
- Out-of-range din (h=31, m=63, s=63): displays "31.63.63" with no X on sel or seg.
- rst pulsed during slot 3:
  - Next edge gives sel=3F, seg=FF.
  - Scan restarts at idx 0 showing 00.00.00.
  - Previously latched snap is discarded.
- BLANK_TIME=0 build: sel is never 3F after the first registered cycle, and exactly one sel bit is low on every cycle.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: field layout of the
// packed time word, active-low segment codes and decimal-point placement.
package seg_pkg;

  localparam int NUM_DIGITS = 6;

  localparam int HOUR_MSB = 16;
  localparam int HOUR_LSB = 12;
  localparam int MIN_MSB  = 11;
  localparam int MIN_LSB  = 6;
  localparam int SEC_MSB  = 5;
  localparam int SEC_LSB  = 0;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [5:0] DP_MASK   = 6'b010100;

  // Active-low codes, bit 7 is the decimal point (kept off here).
  localparam logic [7:0] SEG_CODE [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  // Digits above 9 cannot arise from a 6-bit field split, but blank them anyway.
  function automatic logic [7:0] seg_encode(input logic [3:0] digit);
    seg_encode = SEG_BLANK;
    for (int i = 0; i < 10; i++) begin
      if (digit == 4'(i)) seg_encode = SEG_CODE[i];
    end
  endfunction

endpackage

// File: rtl/bin2bcd_2d.sv
// Combinational split of a 6-bit binary value (0..63) into two decimal digits.
module bin2bcd_2d
  import seg_pkg::*;
(
  input  logic [5:0] bin_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o
);

  assign tens_o = 4'(bin_i / 6'd10);
  assign ones_o = 4'(bin_i % 6'd10);

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 6-digit common-anode display driver with a per-frame snapshot
// of the time word and a blanking gap at the start of every digit slot.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_TIME  = 50_000,
  parameter int BLANK_TIME = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [16:0] din,
  output logic [5:0]  sel,
  output logic [7:0]  seg
);

  localparam int CW = $clog2(SCAN_TIME);
  localparam logic [CW-1:0] CNT_MAX  = CW'(SCAN_TIME - 1);
  localparam logic [2:0]    IDX_LAST = 3'(NUM_DIGITS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [16:0]   snap_q, snap_d;
  logic [5:0]    sel_q, sel_d;
  logic [7:0]    seg_q, seg_d;

  logic          cnt_last;
  logic          blank;
  logic [3:0]    sec_tens, sec_ones;
  logic [3:0]    min_tens, min_ones;
  logic [3:0]    hour_tens, hour_ones;
  logic [3:0]    digit;
  logic          dp;

  assign cnt_last = (cnt_q == CNT_MAX);

  generate
    if (BLANK_TIME == 0) begin : g_no_blank
      assign blank = 1'b0;
    end else begin : g_blank
      assign blank = (cnt_q < CW'(BLANK_TIME));
    end
  endgenerate

  bin2bcd_2d u_sec (
    .bin_i  (snap_q[SEC_MSB:SEC_LSB]),
    .tens_o (sec_tens),
    .ones_o (sec_ones)
  );

  bin2bcd_2d u_min (
    .bin_i  (snap_q[MIN_MSB:MIN_LSB]),
    .tens_o (min_tens),
    .ones_o (min_ones)
  );

  bin2bcd_2d u_hour (
    .bin_i  ({1'b0, snap_q[HOUR_MSB:HOUR_LSB]}),
    .tens_o (hour_tens),
    .ones_o (hour_ones)
  );

  // Snapshot only at the very last cycle of a frame so a frame never tears.
  always_comb begin
    cnt_d  = cnt_last ? '0 : cnt_q + CW'(1);
    idx_d  = idx_q;
    snap_d = snap_q;
    if (cnt_last) begin
      idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
      if (idx_q == IDX_LAST) snap_d = din;
    end
  end

  always_comb begin
    digit = 4'd0;
    dp    = 1'b0;
    case (idx_q)
      3'd0: begin digit = sec_ones;  dp = DP_MASK[0]; end
      3'd1: begin digit = sec_tens;  dp = DP_MASK[1]; end
      3'd2: begin digit = min_ones;  dp = DP_MASK[2]; end
      3'd3: begin digit = min_tens;  dp = DP_MASK[3]; end
      3'd4: begin digit = hour_ones; dp = DP_MASK[4]; end
      3'd5: begin digit = hour_tens; dp = DP_MASK[5]; end
      default: begin digit = 4'd0;   dp = 1'b0;       end
    endcase
  end

  always_comb begin
    sel_d = ~(6'b1 << idx_q);
    seg_d = seg_encode(digit) & {~dp, 7'h7F};
    if (blank) begin
      sel_d = 6'h3F;
      seg_d = SEG_BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= 3'd0;
      snap_q <= '0;
      sel_q  <= 6'h3F;
      seg_q  <= SEG_BLANK;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      sel_q  <= sel_d;
      seg_q  <= seg_d;
    end
  end

  assign sel = sel_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench: two drivers (blanking and no blanking) share stimulus and
// are compared every cycle against a frame-position model of the display.
module tb_seg_scan_driver;

  localparam int ST    = 8;
  localparam int BT    = 2;
  localparam int FRAME = 6 * ST;

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] din;
  logic [5:0]  sel, sel0;
  logic [7:0]  seg, seg0;

  int          checks = 0;
  int          fails  = 0;
  int          p      = 0;
  logic [16:0] snapM  = '0;
  logic [7:0]  obsFrame [0:5];

  localparam logic [7:0] CODES [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  seg_scan_driver #(.SCAN_TIME(ST), .BLANK_TIME(BT)) dut (
    .clk (clk), .rst (rst), .din (din), .sel (sel), .seg (seg)
  );

  seg_scan_driver #(.SCAN_TIME(ST), .BLANK_TIME(0)) dut0 (
    .clk (clk), .rst (rst), .din (din), .sel (sel0), .seg (seg0)
  );

  always #5 clk = ~clk;

  // Display seen at frame position pos for a given latched time word.
  function automatic logic [7:0] modelSeg(input int pos, input logic [16:0] t, input int blankLen);
    int slot, off, val, d;
    logic [7:0] code;
    slot = pos / ST;
    off  = pos % ST;
    if (off < blankLen) return 8'hFF;
    if (slot < 2)      val = int'(t[5:0]);
    else if (slot < 4) val = int'(t[11:6]);
    else               val = int'(t[16:12]);
    d = (slot % 2 == 1) ? val / 10 : val % 10;
    code = CODES[d];
    if (slot == 2 || slot == 4) code = code & 8'h7F;
    return code;
  endfunction

  function automatic logic [5:0] modelSel(input int pos, input int blankLen);
    if ((pos % ST) < blankLen) return 6'h3F;
    return 6'h3F & ~(6'(1) << (pos / ST));
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [16:0] newDin, input logic newRst);
    din = newDin;
    rst = newRst;
  endtask

  task automatic tick();
    logic        rstS;
    logic [16:0] dinS;
    logic [5:0]  eSel, eSel0;
    logic [7:0]  eSeg, eSeg0;
    int          pos;
    @(posedge clk);
    rstS = rst;
    dinS = din;
    pos  = p;
    if (rstS) begin
      eSel = 6'h3F; eSeg = 8'hFF; eSel0 = 6'h3F; eSeg0 = 8'hFF;
      p = 0;
      snapM = '0;
    end else begin
      eSel  = modelSel(pos, BT);
      eSeg  = modelSeg(pos, snapM, BT);
      eSel0 = modelSel(pos, 0);
      eSeg0 = modelSeg(pos, snapM, 0);
      if (pos == FRAME - 1) snapM = dinS;
      p = (pos + 1) % FRAME;
    end
    #1;
    checkOutput("sel", {2'b00, sel}, {2'b00, eSel});
    checkOutput("seg", seg, eSeg);
    checkOutput("sel_noblank", {2'b00, sel0}, {2'b00, eSel0});
    checkOutput("seg_noblank", seg0, eSeg0);
    if (!rstS) begin
      checkOutput("onehot_noblank", 8'($countones(~sel0)), 8'd1);
      if ((pos % ST) == ST - 1) obsFrame[pos / ST] = seg;
    end
  endtask

  task automatic runCycles(input int n, input bit randEvery, input bit randSparse);
    for (int k = 0; k < n; k++) begin
      if (randEvery) din = 17'($urandom);
      else if (randSparse && $urandom_range(7) == 0) din = 17'($urandom);
      tick();
    end
  endtask

  task automatic checkFrame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3,
                            input logic [7:0] e4, input logic [7:0] e5);
    checkOutput({tag, "_d0"}, obsFrame[0], e0);
    checkOutput({tag, "_d1"}, obsFrame[1], e1);
    checkOutput({tag, "_d2"}, obsFrame[2], e2);
    checkOutput({tag, "_d3"}, obsFrame[3], e3);
    checkOutput({tag, "_d4"}, obsFrame[4], e4);
    checkOutput({tag, "_d5"}, obsFrame[5], e5);
  endtask

  initial begin
    int k;
    applyStimulus(17'd0, 1'b1);
    tick();
    tick();
    applyStimulus(17'd0, 1'b0);

    runCycles(FRAME, 1'b0, 1'b0);
    checkFrame("zero_frame", 8'hC0, 8'hC0, 8'h40, 8'hC0, 8'h40, 8'hC0);

    runCycles(20, 1'b0, 1'b0);
    applyStimulus({5'd12, 6'd34, 6'd56}, 1'b0);
    runCycles(FRAME - 20, 1'b0, 1'b0);
    checkFrame("midframe_old", 8'hC0, 8'hC0, 8'h40, 8'hC0, 8'h40, 8'hC0);
    runCycles(FRAME, 1'b0, 1'b0);
    checkFrame("time_123456", 8'h82, 8'h92, 8'h19, 8'hB0, 8'h24, 8'hF9);

    runCycles(FRAME, 1'b1, 1'b0);
    applyStimulus({5'd31, 6'd63, 6'd63}, 1'b0);
    runCycles(FRAME, 1'b0, 1'b0);
    runCycles(FRAME, 1'b0, 1'b0);
    checkFrame("out_of_range", 8'hB0, 8'h82, 8'h30, 8'h82, 8'h79, 8'hB0);
    checkOutput("no_x_sel", 8'(^{sel, seg} === 1'bx), 8'd0);

    k = 0;
    while (k < 100 && !(p / ST == 3 && p % ST == 4)) begin
      tick();
      k++;
    end
    checkOutput("reach_slot3", 8'(p / ST == 3 && p % ST == 4), 8'd1);
    applyStimulus(din, 1'b1);
    tick();
    applyStimulus(din, 1'b0);
    runCycles(FRAME, 1'b0, 1'b0);
    checkFrame("after_reset", 8'hC0, 8'hC0, 8'h40, 8'hC0, 8'h40, 8'hC0);

    runCycles(4 * FRAME, 1'b0, 1'b1);

    $display("[TB] %0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
